// File: rtl/sad_engine_if.sv
// Bus bundle for sad_engine: control strobes, frame/window memory read ports and search results.
// Signal prefixes are from the engine's point of view (i_ into the engine, o_ out of it).
interface sad_engine_if #(
    parameter int FRAME_W = 64,
    parameter int FRAME_H = 64,
    parameter int WIN_W   = 4,
    parameter int WIN_H   = 4
);
    localparam int SAD_W = 8 + $clog2(WIN_W * WIN_H);
    localparam int FA_W  = $clog2(FRAME_W * FRAME_H);
    localparam int WA_W  = $clog2(WIN_W * WIN_H);
    localparam int ROW_W = $clog2(FRAME_H);
    localparam int COL_W = $clog2(FRAME_W);

    logic             i_trigger;
    logic             i_setZeroes;
    logic [FA_W-1:0]  o_frameAddr;
    logic [7:0]       i_frameData;
    logic [WA_W-1:0]  o_winAddr;
    logic [7:0]       i_winData;
    logic [SAD_W-1:0] o_minSad;
    logic [ROW_W-1:0] o_minRow;
    logic [COL_W-1:0] o_minCol;
    logic             o_busy;
    logic             o_done;

    modport master (
        output i_trigger, i_setZeroes, i_frameData, i_winData,
        input  o_frameAddr, o_winAddr, o_minSad, o_minRow, o_minCol, o_busy, o_done
    );

    modport slave (
        input  i_trigger, i_setZeroes, i_frameData, i_winData,
        output o_frameAddr, o_winAddr, o_minSad, o_minRow, o_minCol, o_busy, o_done
    );
endinterface

// File: rtl/sad_engine.sv
// Exhaustive block-matching search: finds the frame position whose window SAD is smallest.
// Optional feature: define SAD_EARLY_TERM_EN to abandon a candidate once its partial SAD reaches the running minimum.
module sad_engine #(
    parameter int FRAME_W = 64,
    parameter int FRAME_H = 64,
    parameter int WIN_W   = 4,
    parameter int WIN_H   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    sad_engine_if.slave bus
);
    localparam int N     = WIN_W * WIN_H;
    localparam int SAD_W = 8 + $clog2(N);
    localparam int FA_W  = $clog2(FRAME_W * FRAME_H);
    localparam int WA_W  = $clog2(N);
    localparam int ROW_W = $clog2(FRAME_H);
    localparam int COL_W = $clog2(FRAME_W);
    localparam int WR_W  = (WIN_H > 1) ? $clog2(WIN_H) : 1;
    localparam int WC_W  = (WIN_W > 1) ? $clog2(WIN_W) : 1;

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(FRAME_H - WIN_H);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(FRAME_W - WIN_W);
    localparam logic [WR_W-1:0]  WR_LAST  = WR_W'(WIN_H - 1);
    localparam logic [WC_W-1:0]  WC_LAST  = WC_W'(WIN_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        COMPARE,
        DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] r_col;
    logic [WR_W-1:0]  r_wr;
    logic [WC_W-1:0]  r_wc;
    logic             r_pend;
    logic [SAD_W-1:0] r_acc;
    logic [SAD_W-1:0] r_minSad;
    logic [ROW_W-1:0] r_minRow;
    logic [COL_W-1:0] r_minCol;
    logic             r_busy;
    logic             r_done;

    logic             w_lastElem;
    logic             w_lastCand;
    logic             w_start;
    logic             w_clearMin;
    logic             w_advance;
    logic [7:0]       w_diff;
    logic [SAD_W-1:0] w_sum;
    logic [FA_W-1:0]  w_frameAddr;
    logic [WA_W-1:0]  w_winAddr;
`ifdef SAD_EARLY_TERM_EN
    logic             w_abort;
`endif

    assign w_lastElem = (r_wr == WR_LAST) && (r_wc == WC_LAST);
    assign w_lastCand = (r_row == ROW_LAST) && (r_col == COL_LAST);
    assign w_diff     = (bus.i_frameData > bus.i_winData) ? (bus.i_frameData - bus.i_winData)
                                                          : (bus.i_winData - bus.i_frameData);
    assign w_sum      = r_acc + SAD_W'(w_diff);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_start    = 1'b0;
        w_clearMin = 1'b0;
`ifdef SAD_EARLY_TERM_EN
        w_abort    = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (bus.i_trigger) begin
                    w_next  = FETCH;
                    w_start = 1'b1;
                end else if (bus.i_setZeroes) begin
                    w_clearMin = 1'b1;
                end
            end
            FETCH:   if (w_lastElem) w_next = DRAIN;
            DRAIN:   w_next = COMPARE;
            COMPARE: w_next = w_lastCand ? DONE : FETCH;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
`ifdef SAD_EARLY_TERM_EN
        // A partial sum that already ties the best can never win, so skip to the next candidate.
        if ((r_state == FETCH || r_state == DRAIN) && r_pend && (w_sum >= r_minSad)) begin
            w_abort = 1'b1;
            w_next  = w_lastCand ? DONE : FETCH;
        end
`endif
    end

`ifdef SAD_EARLY_TERM_EN
    assign w_advance = (r_state == COMPARE) || w_abort;
`else
    assign w_advance = (r_state == COMPARE);
`endif

    always_comb begin
        w_frameAddr = '0;
        w_winAddr   = '0;
        if (r_state == FETCH) begin
            w_frameAddr = FA_W'((int'(r_row) + int'(r_wr)) * FRAME_W + int'(r_col) + int'(r_wc));
            w_winAddr   = WA_W'(int'(r_wr) * WIN_W + int'(r_wc));
        end
    end

    // r_pend marks that the pair addressed last cycle is on the data inputs now.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= 1'b0;
            r_acc  <= '0;
        end else begin
`ifdef SAD_EARLY_TERM_EN
            r_pend <= (r_state == FETCH) && !w_abort;
`else
            r_pend <= (r_state == FETCH);
`endif
            if (w_start || w_advance) begin
                r_acc <= '0;
            end else if (r_pend) begin
                r_acc <= w_sum;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr <= '0;
            r_wc <= '0;
        end else if (w_start || w_advance) begin
            r_wr <= '0;
            r_wc <= '0;
        end else if (r_state == FETCH) begin
            if (r_wc == WC_LAST) begin
                r_wc <= '0;
                r_wr <= (r_wr == WR_LAST) ? '0 : r_wr + 1'b1;
            end else begin
                r_wc <= r_wc + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row <= '0;
            r_col <= '0;
        end else if (w_start) begin
            r_row <= '0;
            r_col <= '0;
        end else if (w_advance) begin
            if (w_lastCand) begin
                r_row <= '0;
                r_col <= '0;
            end else if (r_col == COL_LAST) begin
                r_col <= '0;
                r_row <= r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Loading the minimum with all ones guarantees the first candidate always wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_minSad <= '0;
            r_minRow <= '0;
            r_minCol <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= (r_state == DONE);
            if (w_start) begin
                r_minSad <= '1;
                r_minRow <= '0;
                r_minCol <= '0;
                r_busy   <= 1'b1;
            end else if (w_clearMin) begin
                r_minSad <= '0;
                r_minRow <= '0;
                r_minCol <= '0;
            end else if ((r_state == COMPARE) && (r_acc < r_minSad)) begin
                r_minSad <= r_acc;
                r_minRow <= r_row;
                r_minCol <= r_col;
            end
            if (r_state == DONE) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign bus.o_frameAddr = w_frameAddr;
    assign bus.o_winAddr   = w_winAddr;
    assign bus.o_minSad    = r_minSad;
    assign bus.o_minRow    = r_minRow;
    assign bus.o_minCol    = r_minCol;
    assign bus.o_busy      = r_busy;
    assign bus.o_done      = r_done;
endmodule

// File: tb/tb_sad_engine.sv
// Scoreboard bench for sad_engine on an 8x8 frame with a 2x2 window.
// Expected results come from a brute-force search over the frame arrays held here.
module tb_sad_engine;
    localparam int FRAME_W       = 8;
    localparam int FRAME_H       = 8;
    localparam int WIN_W         = 2;
    localparam int WIN_H         = 2;
    localparam int N             = WIN_W * WIN_H;
    localparam int P             = (FRAME_W - WIN_W + 1) * (FRAME_H - WIN_H + 1);
    localparam int SEARCH_CYCLES = P * (N + 2) + 1;

    typedef struct {
        int sad;
        int row;
        int col;
        int trigEdge;
        bit faster;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cycle       = 0;
    int   testsRun    = 0;
    int   testsFailed = 0;
    exp_t expQ[$];

    logic [7:0] frame [FRAME_W*FRAME_H];
    logic [7:0] win   [N];

    sad_engine_if #(.FRAME_W(FRAME_W), .FRAME_H(FRAME_H), .WIN_W(WIN_W), .WIN_H(WIN_H)) busIf ();

    sad_engine #(
        .FRAME_W(FRAME_W),
        .FRAME_H(FRAME_H),
        .WIN_W  (WIN_W),
        .WIN_H  (WIN_H)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (busIf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Synchronous-read memories: data follows its address by one cycle.
    always @(posedge clk) begin
        busIf.i_frameData <= frame[busIf.o_frameAddr];
        busIf.i_winData   <= win[busIf.o_winAddr];
    end

    task automatic checkEq(input string name, input int actual, input int expected);
        testsRun++;
        if (actual != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic exp_t refModel(input bit faster);
        exp_t e;
        int   s;
        int   d;
        e.sad      = -1;
        e.row      = 0;
        e.col      = 0;
        e.trigEdge = 0;
        e.faster   = faster;
        for (int r = 0; r <= FRAME_H - WIN_H; r++) begin
            for (int c = 0; c <= FRAME_W - WIN_W; c++) begin
                s = 0;
                for (int i = 0; i < WIN_H; i++) begin
                    for (int j = 0; j < WIN_W; j++) begin
                        d = int'(frame[(r + i) * FRAME_W + c + j]) - int'(win[i * WIN_W + j]);
                        s += (d < 0) ? -d : d;
                    end
                end
                if (e.sad < 0 || s < e.sad) begin
                    e.sad = s;
                    e.row = r;
                    e.col = c;
                end
            end
        end
        return e;
    endfunction

    task automatic applyStimulus(input bit faster);
        exp_t e;
        e = refModel(faster);
        busIf.i_trigger = 1'b1;
        @(posedge clk);
        #1;
        busIf.i_trigger = 1'b0;
        e.trigEdge = cycle;
        expQ.push_back(e);
        checkEq("busyAfterTrigger", int'(busIf.o_busy), 1);
    endtask

    task automatic checkOutput();
        exp_t e;
        int   lat;
        if (expQ.size() == 0) begin
            checkEq("unexpectedDone", int'(busIf.o_done), 0);
            return;
        end
        e   = expQ.pop_front();
        lat = cycle - e.trigEdge;
        checkEq("minSad", int'(busIf.o_minSad), e.sad);
        checkEq("minRow", int'(busIf.o_minRow), e.row);
        checkEq("minCol", int'(busIf.o_minCol), e.col);
        checkEq("busyAtDone", int'(busIf.o_busy), 0);
`ifdef SAD_EARLY_TERM_EN
        checkEq("latencyWithinBound", int'(lat <= SEARCH_CYCLES), 1);
        if (e.faster) checkEq("latencyReduced", int'(lat < SEARCH_CYCLES), 1);
`else
        checkEq("latency", lat, SEARCH_CYCLES);
`endif
    endtask

    task automatic waitDone();
        int n = 0;
        while (expQ.size() != 0 && n < SEARCH_CYCLES + 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (expQ.size() != 0) begin
            checkEq("doneTimeout", expQ.size(), 0);
            expQ.delete();
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkEq({tag, "Sad"},       int'(busIf.o_minSad), 0);
        checkEq({tag, "Row"},       int'(busIf.o_minRow), 0);
        checkEq({tag, "Col"},       int'(busIf.o_minCol), 0);
        checkEq({tag, "Busy"},      int'(busIf.o_busy), 0);
        checkEq({tag, "Done"},      int'(busIf.o_done), 0);
        checkEq({tag, "FrameAddr"}, int'(busIf.o_frameAddr), 0);
        checkEq({tag, "WinAddr"},   int'(busIf.o_winAddr), 0);
    endtask

    task automatic fillRandom(input int maxV);
        for (int i = 0; i < FRAME_W * FRAME_H; i++) frame[i] = 8'($urandom_range(0, maxV));
        for (int i = 0; i < N; i++) win[i] = 8'($urandom_range(0, maxV));
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (busIf.o_done) checkOutput();
        end
    end

    initial begin
        busIf.i_trigger   = 1'b0;
        busIf.i_setZeroes = 1'b0;
        for (int i = 0; i < FRAME_W * FRAME_H; i++) frame[i] = 8'd0;
        for (int i = 0; i < N; i++) win[i] = 8'd0;

        repeat (3) @(posedge clk);
        #1;
        checkAllZero("reset");

        // Trigger on the very first edge after release, all-zero images.
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0);
        waitDone();

        // Exact patch hidden in a flat frame.
        for (int i = 0; i < FRAME_W * FRAME_H; i++) frame[i] = 8'd10;
        frame[5 * FRAME_W + 3] = 8'd1;
        frame[5 * FRAME_W + 4] = 8'd2;
        frame[6 * FRAME_W + 3] = 8'd3;
        frame[6 * FRAME_W + 4] = 8'd4;
        for (int i = 0; i < N; i++) win[i] = 8'(i + 1);
        applyStimulus(1'b1);
        waitDone();
        checkEq("patchSad", int'(busIf.o_minSad), 0);
        checkEq("patchRow", int'(busIf.o_minRow), 5);
        checkEq("patchCol", int'(busIf.o_minCol), 3);

        // Largest possible SAD everywhere, so the tie goes to (0,0).
        for (int i = 0; i < FRAME_W * FRAME_H; i++) frame[i] = 8'd255;
        for (int i = 0; i < N; i++) win[i] = 8'd0;
        applyStimulus(1'b0);
        waitDone();
        checkEq("maxSad", int'(busIf.o_minSad), 1020);
        checkEq("maxRow", int'(busIf.o_minRow), 0);
        checkEq("maxCol", int'(busIf.o_minCol), 0);
        repeat (10) @(posedge clk);
        #1;
        checkEq("resultsHeld", int'(busIf.o_minSad), 1020);
        busIf.i_setZeroes = 1'b1;
        @(posedge clk);
        #1;
        busIf.i_setZeroes = 1'b0;
        checkAllZero("setZeroes");

        for (int k = 0; k < 3; k++) begin
            fillRandom((k == 0) ? 3 : 255);
            applyStimulus(1'b0);
            waitDone();
        end

        // Trigger and SetZeroes pulsed 100 cycles into a search must be ignored.
        fillRandom(255);
        applyStimulus(1'b0);
        repeat (99) @(posedge clk);
        #1;
        busIf.i_trigger   = 1'b1;
        busIf.i_setZeroes = 1'b1;
        @(posedge clk);
        #1;
        busIf.i_trigger   = 1'b0;
        busIf.i_setZeroes = 1'b0;
        checkEq("busyMidSearch", int'(busIf.o_busy), 1);
        waitDone();

        // Trigger beats SetZeroes when both arrive in idle.
        fillRandom(15);
        busIf.i_setZeroes = 1'b1;
        applyStimulus(1'b0);
        busIf.i_setZeroes = 1'b0;
        waitDone();

        // Reset in the middle of a search aborts it without a Done pulse.
        fillRandom(255);
        applyStimulus(1'b0);
        repeat (50) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkAllZero("midReset");
        expQ.delete();
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        fillRandom(7);
        applyStimulus(1'b0);
        waitDone();

        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
